// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEF_DW           = 32;
  localparam int unsigned DEF_MAX_BURST    = 8;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } arb_state_t;

  // Counter width able to hold 0..limit-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// DMA/loader beat port: request held until granted; read data valid with the grant.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
) ();

  logic          req;
  logic          we;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rdata);

endinterface

// File: rtl/arb_counter.sv
// Clearable up-counter over 0..LIMIT-1 that either saturates or wraps; term flags LIMIT-1.
module arb_counter #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned LIMIT = 4,
  parameter bit          WRAP  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic term
);

  logic [WIDTH-1:0] count;

  assign term = (count == WIDTH'(LIMIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      if (!term) begin
        count <= count + WIDTH'(1);
      end else if (WRAP) begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter between the CPU MEM stage and a DMA port; stalls the
// pipeline while the DMA owns memory, with bounded bursts and a starvation limit.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST    = DEF_MAX_BURST,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned DW           = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemReqM,
  input  logic          MemWriteM,
  input  logic [DW-1:0] ALUResultM,
  input  logic [DW-1:0] WriteDataM,
  output logic [DW-1:0] ReadDataM,
  output logic          StallM,
  dmem_arbiter_if.slave dma,
  output logic          dm_we,
  output logic [DW-1:0] dm_a,
  output logic [DW-1:0] dm_wd,
  input  logic [DW-1:0] dm_rd,
  output logic          dma_owner
);

  localparam int unsigned SW = cnt_width(STARVE_LIMIT);
  localparam int unsigned BW = cnt_width(MAX_BURST);

  arb_state_t state, state_next;
  logic       starve_inc, starve_clr, starve_term;
  logic       beat_inc, beat_clr, beat_term;
  logic       dm_we_mux;

  arb_counter #(.WIDTH(SW), .LIMIT(STARVE_LIMIT), .WRAP(1'b0)) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (starve_clr),
    .inc   (starve_inc),
    .term  (starve_term)
  );

  arb_counter #(.WIDTH(BW), .LIMIT(MAX_BURST), .WRAP(1'b1)) u_beat_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (beat_clr),
    .inc   (beat_inc),
    .term  (beat_term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_CPU;
    end else begin
      state <= state_next;
    end
  end

  // Ownership decision and the zero-latency dmem mux, both driven by the current owner.
  always_comb begin
    state_next = state;
    dm_we_mux  = 1'b0;
    dm_a       = ALUResultM;
    dm_wd      = WriteDataM;
    ReadDataM  = '0;
    StallM     = 1'b0;
    dma.gnt    = 1'b0;
    dma.rdata  = '0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    beat_inc   = 1'b0;
    beat_clr   = 1'b0;

    case (state)
      S_CPU: begin
        dm_we_mux  = MemReqM & MemWriteM;
        ReadDataM  = dm_rd;
        starve_inc = dma.req & MemReqM;
        starve_clr = ~dma.req;
        beat_clr   = 1'b1;
        if (dma.req && (!MemReqM || starve_term)) begin
          state_next = S_DMA;
        end
      end
      S_DMA: begin
        dm_a       = dma.addr;
        dm_wd      = dma.wdata;
        dm_we_mux  = dma.req & dma.we;
        dma.gnt    = dma.req;
        dma.rdata  = dma.req ? dm_rd : '0;
        StallM     = MemReqM;
        starve_clr = 1'b1;
        beat_inc   = dma.req;
        // Hand back when the DMA goes idle or a full burst has run while the CPU waits.
        if (!dma.req || (beat_term && MemReqM)) begin
          state_next = S_CPU;
          beat_clr   = 1'b1;
        end
      end
      default: begin
        state_next = S_CPU;
      end
    endcase
  end

  // Keep the memory write strobe quiet while reset is held.
  assign dm_we     = dm_we_mux & reset;
  assign dma_owner = (state == S_DMA);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural single-port dmem.
module tb_dmem_arbiter;

  localparam int unsigned DW = dmem_arb_pkg::DEF_DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemReqM, MemWriteM;
  logic [DW-1:0] ALUResultM, WriteDataM, ReadDataM;
  logic          StallM, dm_we, dma_owner;
  logic [DW-1:0] dm_a, dm_wd, dm_rd;
  logic [31:0]   mem [256];

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if #(.DW(DW)) dma_bus ();

  dmem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .MemReqM    (MemReqM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .dma        (dma_bus),
    .dm_we      (dm_we),
    .dm_a       (dm_a),
    .dm_wd      (dm_wd),
    .dm_rd      (dm_rd),
    .dma_owner  (dma_owner)
  );

  always #5 clk = ~clk;

  // Word-indexed memory, combinational read; preloaded with 0x1000_0000+index during reset.
  assign dm_rd = mem[dm_a[9:2]];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (dm_we) begin
      mem[dm_a[9:2]] <= dm_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with both requesters active
    reset = 1'b1; MemReqM = 1'b1; MemWriteM = 1'b1;
    ALUResultM = 32'h40; WriteDataM = 32'h1234;
    dma_bus.req = 1'b1; dma_bus.we = 1'b1; dma_bus.addr = 32'h100; dma_bus.wdata = 32'h55;
    #1 reset = 1'b0;
    settle();
    chk("rst_stall", 32'(StallM), 32'h0);
    chk("rst_gnt", 32'(dma_bus.gnt), 32'h0);
    chk("rst_dm_we", 32'(dm_we), 32'h0);
    chk("rst_owner", 32'(dma_owner), 32'h0);
    tick(); tick(); settle();
    chk("rst_hold_gnt", 32'(dma_bus.gnt), 32'h0);
    chk("rst_hold_dm_we", 32'(dm_we), 32'h0);
    dma_bus.req = 1'b0; MemWriteM = 1'b0; reset = 1'b1;
    settle();
    chk("post_rst_owner", 32'(dma_owner), 32'h0);
    chk("post_rst_dm_a", dm_a, 32'h40);

    // CPU-only store then load
    tick();
    MemReqM = 1'b1; MemWriteM = 1'b1; ALUResultM = 32'h40; WriteDataM = 32'hDEAD_BEEF;
    settle();
    chk("cpu_st_we", 32'(dm_we), 32'h1);
    chk("cpu_st_a", dm_a, 32'h40);
    chk("cpu_st_wd", dm_wd, 32'hDEAD_BEEF);
    chk("cpu_st_stall", 32'(StallM), 32'h0);
    tick();
    MemWriteM = 1'b0;
    settle();
    chk("cpu_ld_data", ReadDataM, 32'hDEAD_BEEF);
    chk("cpu_ld_we", 32'(dm_we), 32'h0);
    chk("cpu_ld_stall", 32'(StallM), 32'h0);

    // Idle handover and three DMA writes
    tick();
    MemReqM = 1'b0;
    dma_bus.req = 1'b1; dma_bus.we = 1'b1; dma_bus.addr = 32'h100; dma_bus.wdata = 32'hA0;
    settle();
    chk("ho_owner_t", 32'(dma_owner), 32'h0);
    chk("ho_gnt_t", 32'(dma_bus.gnt), 32'h0);
    tick(); settle();
    chk("ho_owner_t1", 32'(dma_owner), 32'h1);
    for (int i = 0; i < 3; i++) begin
      dma_bus.addr = 32'h100 + 32'(4 * i); dma_bus.wdata = 32'hA0 + 32'(i);
      settle();
      chk("dma_wr_gnt", 32'(dma_bus.gnt), 32'h1);
      chk("dma_wr_we", 32'(dm_we), 32'h1);
      chk("dma_wr_a", dm_a, 32'h100 + 32'(4 * i));
      tick();
    end
    dma_bus.req = 1'b0;
    settle();
    chk("dma_idle_gnt", 32'(dma_bus.gnt), 32'h0);
    chk("dma_idle_owner", 32'(dma_owner), 32'h1);
    tick();
    MemReqM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h104;
    settle();
    chk("back_owner", 32'(dma_owner), 32'h0);
    chk("dma_wr1_data", ReadDataM, 32'hA1);
    tick();
    ALUResultM = 32'h108;
    settle();
    chk("dma_wr2_data", ReadDataM, 32'hA2);

    // Starvation: CPU busy every cycle, DMA forced in after four cycles
    tick();
    ALUResultM = 32'h40;
    dma_bus.req = 1'b1; dma_bus.we = 1'b0; dma_bus.addr = 32'h180;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("starve_owner", 32'(dma_owner), 32'h0);
      chk("starve_stall", 32'(StallM), 32'h0);
      chk("starve_cpu_rd", ReadDataM, 32'hDEAD_BEEF);
      tick();
    end
    MemWriteM = 1'b1; WriteDataM = 32'hBAD0_BAD0;
    for (int i = 0; i < 8; i++) begin
      dma_bus.addr = 32'h180 + 32'(4 * i);
      settle();
      chk("burst_owner", 32'(dma_owner), 32'h1);
      chk("burst_gnt", 32'(dma_bus.gnt), 32'h1);
      chk("burst_stall", 32'(StallM), 32'h1);
      chk("burst_no_cpu_we", 32'(dm_we), 32'h0);
      chk("burst_cpu_rd0", ReadDataM, 32'h0);
      chk("burst_rdata", dma_bus.rdata, 32'h1000_0060 + 32'(i));
      tick();
    end
    MemWriteM = 1'b0;
    settle();
    chk("burst_end_owner", 32'(dma_owner), 32'h0);
    chk("burst_end_stall", 32'(StallM), 32'h0);
    chk("burst_end_gnt", 32'(dma_bus.gnt), 32'h0);
    chk("burst_end_rdata", dma_bus.rdata, 32'h0);
    chk("stalled_st_dropped", ReadDataM, 32'hDEAD_BEEF);

    // 20-beat read with CPU idle: bursts wrap instead of handing back
    tick();
    MemReqM = 1'b0; dma_bus.req = 1'b1; dma_bus.we = 1'b0; dma_bus.addr = 32'h200;
    settle();
    chk("wrap_owner_t", 32'(dma_owner), 32'h0);
    tick();
    for (int i = 0; i < 20; i++) begin
      dma_bus.addr = 32'h200 + 32'(4 * i);
      settle();
      chk("wrap_owner", 32'(dma_owner), 32'h1);
      chk("wrap_gnt", 32'(dma_bus.gnt), 32'h1);
      chk("wrap_rdata", dma_bus.rdata, 32'h1000_0080 + 32'(i));
      tick();
    end
    dma_bus.req = 1'b0;
    settle();
    chk("wrap_done_gnt", 32'(dma_bus.gnt), 32'h0);
    tick(); settle();
    chk("wrap_done_owner", 32'(dma_owner), 32'h0);

    // Async reset at beat 3, then a fresh burst must run the full eight beats
    tick();
    dma_bus.req = 1'b1; dma_bus.addr = 32'h200;
    tick();
    for (int i = 0; i < 3; i++) begin
      dma_bus.addr = 32'h200 + 32'(4 * i);
      settle();
      chk("pre_rst_gnt", 32'(dma_bus.gnt), 32'h1);
      tick();
    end
    dma_bus.addr = 32'h20C; MemReqM = 1'b1;
    settle();
    chk("beat3_stall", 32'(StallM), 32'h1);
    reset = 1'b0;
    settle();
    chk("mid_rst_owner", 32'(dma_owner), 32'h0);
    chk("mid_rst_gnt", 32'(dma_bus.gnt), 32'h0);
    chk("mid_rst_stall", 32'(StallM), 32'h0);
    chk("mid_rst_dm_we", 32'(dm_we), 32'h0);
    tick();
    reset = 1'b1; MemReqM = 1'b0; dma_bus.addr = 32'h200;
    settle();
    chk("restart_owner_t", 32'(dma_owner), 32'h0);
    tick();
    MemReqM = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dma_bus.addr = 32'h200 + 32'(4 * i);
      settle();
      chk("restart_gnt", 32'(dma_bus.gnt), 32'h1);
      chk("restart_stall", 32'(StallM), 32'h1);
      chk("restart_rdata", dma_bus.rdata, 32'h1000_0080 + 32'(i));
      tick();
    end
    settle();
    chk("restart_end_owner", 32'(dma_owner), 32'h0);
    chk("restart_end_stall", 32'(StallM), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
